// File: rtl/shot_controller.sv
// Fire-request sequencer for one 10x10 board: validates shots, drives shot/sunk pulses, scores hits.
// Latency: result 2 cycles after accept (INVALID/REPEAT), 3 (MISS/HIT), 4 (SUNK); ready low while busy.
module shot_controller #(
   parameter int NUM_SHIPS = 5,
   parameter int ID_W      = 3,
   parameter int LEN_W     = 3
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       map_load,
   input  logic [100*ID_W-1:0]        ship_id_flat,
   input  logic [NUM_SHIPS*LEN_W-1:0] ship_len_flat,
   input  logic                       fire_valid,
   output logic                       fire_ready,
   input  logic [3:0]                 fire_row,
   input  logic [3:0]                 fire_col,
   output logic [99:0]                shot,
   output logic [99:0]                is_ship,
   output logic [99:0]                ship_sunk,
   output logic                       result_valid,
   output logic [2:0]                 result,
   output logic [ID_W-1:0]            result_ship,
   output logic                       game_over
);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SHOOT, S_SINK, S_RESP} state_t;

   localparam logic [2:0] RES_MISS    = 3'd0;
   localparam logic [2:0] RES_HIT     = 3'd1;
   localparam logic [2:0] RES_SUNK    = 3'd2;
   localparam logic [2:0] RES_REPEAT  = 3'd3;
   localparam logic [2:0] RES_INVALID = 3'd4;

   state_t                       r_state, w_state_nxt;
   logic [100*ID_W-1:0]          r_id_flat;
   logic [NUM_SHIPS*LEN_W-1:0]   r_len_flat;
   logic [LEN_W-1:0]             r_cnt [NUM_SHIPS];
   logic [99:0]                  r_fired;
   logic [3:0]                   r_row, r_col;
   logic [2:0]                   r_result, w_res_nxt;
   logic [ID_W-1:0]              r_ship, w_ship_nxt;
   logic                         r_game_over;

   logic [7:0]                   w_idx;
   logic                         w_in_grid;
   logic [ID_W-1:0]              w_cur_id;
   logic [LEN_W-1:0]             w_cur_len, w_cur_cnt;
   logic                         w_sink_hit;
   logic                         w_game_done;
   logic [11:0]                  w_match [12];
   logic [99:0]                  w_sunk_mask;

   assign w_idx      = 8'(r_row) * 8'd10 + 8'(r_col);
   assign w_in_grid  = (r_row <= 4'd9) && (r_col <= 4'd9);
   assign w_cur_id   = r_id_flat[w_idx*ID_W +: ID_W];
   assign w_sink_hit = ({1'b0, w_cur_cnt} + 1'b1) == {1'b0, w_cur_len};

   always_comb begin
      w_cur_len = '0;
      w_cur_cnt = '0;
      for (int k = 0; k < NUM_SHIPS; k++) begin
         if (w_cur_id == ID_W'(k + 1)) begin
            w_cur_len = r_len_flat[k*LEN_W +: LEN_W];
            w_cur_cnt = r_cnt[k];
         end
      end
   end

   // An empty map never ends the game; at least one ship must be present.
   always_comb begin
      logic any_present, all_sunk;
      any_present = 1'b0;
      all_sunk    = 1'b1;
      for (int k = 0; k < NUM_SHIPS; k++) begin
         if (r_len_flat[k*LEN_W +: LEN_W] != '0) begin
            any_present = 1'b1;
            if (r_cnt[k] != r_len_flat[k*LEN_W +: LEN_W]) all_sunk = 1'b0;
         end
      end
      w_game_done = any_present && all_sunk;
   end

   // Zero border around the match grid clips the 3x3 dilation at the board edges.
   always_comb begin
      for (int r = 0; r < 12; r++) w_match[r] = '0;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++)
            w_match[r+1][c+1] = (r_id_flat[(r*10+c)*ID_W +: ID_W] == r_ship);
   end

   always_comb begin
      w_sunk_mask = '0;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++)
            w_sunk_mask[r*10+c] = |{w_match[r][c +: 3], w_match[r+1][c +: 3], w_match[r+2][c +: 3]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_res_nxt   = r_result;
      w_ship_nxt  = r_ship;
      case (r_state)
         S_IDLE: begin
            if (!map_load && fire_valid && !r_game_over) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (!w_in_grid) begin
               w_res_nxt = RES_INVALID; w_ship_nxt = '0; w_state_nxt = S_RESP;
            end else if (r_fired[w_idx]) begin
               w_res_nxt = RES_REPEAT;  w_ship_nxt = '0; w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_SHOOT;
            end
         end
         S_SHOOT: begin
            if (w_cur_id == '0) begin
               w_res_nxt = RES_MISS; w_ship_nxt = '0; w_state_nxt = S_RESP;
            end else if (w_sink_hit) begin
               w_res_nxt = RES_SUNK; w_ship_nxt = w_cur_id; w_state_nxt = S_SINK;
            end else begin
               w_res_nxt = RES_HIT;  w_ship_nxt = w_cur_id; w_state_nxt = S_RESP;
            end
         end
         S_SINK:  w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_id_flat   <= '0;
         r_len_flat  <= '0;
         for (int k = 0; k < NUM_SHIPS; k++) r_cnt[k] <= '0;
         r_fired     <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_result    <= '0;
         r_ship      <= '0;
         r_game_over <= 1'b0;
      end else begin
         r_result <= w_res_nxt;
         r_ship   <= w_ship_nxt;
         case (r_state)
            S_IDLE: begin
               if (map_load) begin
                  r_id_flat   <= ship_id_flat;
                  r_len_flat  <= ship_len_flat;
                  for (int k = 0; k < NUM_SHIPS; k++) r_cnt[k] <= '0;
                  r_fired     <= '0;
                  r_game_over <= 1'b0;
               end else if (fire_valid && !r_game_over) begin
                  r_row <= fire_row;
                  r_col <= fire_col;
               end
            end
            S_SHOOT: begin
               r_fired[w_idx] <= 1'b1;
               for (int k = 0; k < NUM_SHIPS; k++)
                  if (w_cur_id == ID_W'(k + 1) && r_cnt[k] < w_cur_len)
                     r_cnt[k] <= r_cnt[k] + 1'b1;
            end
            S_RESP: begin
               if (w_game_done) r_game_over <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      is_ship = '0;
      for (int i = 0; i < 100; i++) is_ship[i] = |r_id_flat[i*ID_W +: ID_W];
   end

   assign fire_ready   = (r_state == S_IDLE) && !r_game_over;
   assign shot         = (r_state == S_SHOOT) ? ({{99{1'b0}}, 1'b1} << w_idx) : '0;
   assign ship_sunk    = (r_state == S_SINK) ? w_sunk_mask : '0;
   assign result_valid = (r_state == S_RESP);
   assign result       = r_result;
   assign result_ship  = r_ship;
   assign game_over    = r_game_over;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller: table of fire requests with hand-computed results and pulses.
module tb_shot_controller;
   localparam int NUM_SHIPS = 5;
   localparam int ID_W      = 3;
   localparam int LEN_W     = 3;

   localparam logic [2:0] MISS = 3'd0, HIT = 3'd1, SUNK = 3'd2, REPEAT = 3'd3, INVALID = 3'd4;

   logic                       clk = 1'b0;
   logic                       reset_n;
   logic                       map_load;
   logic [100*ID_W-1:0]        ship_id_flat;
   logic [NUM_SHIPS*LEN_W-1:0] ship_len_flat;
   logic                       fire_valid;
   logic                       fire_ready;
   logic [3:0]                 fire_row, fire_col;
   logic [99:0]                shot, is_ship, ship_sunk;
   logic                       result_valid;
   logic [2:0]                 result;
   logic [ID_W-1:0]            result_ship;
   logic                       game_over;

   shot_controller #(.NUM_SHIPS(NUM_SHIPS), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset_n(reset_n), .map_load(map_load),
      .ship_id_flat(ship_id_flat), .ship_len_flat(ship_len_flat),
      .fire_valid(fire_valid), .fire_ready(fire_ready),
      .fire_row(fire_row), .fire_col(fire_col),
      .shot(shot), .is_ship(is_ship), .ship_sunk(ship_sunk),
      .result_valid(result_valid), .result(result), .result_ship(result_ship),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]      row;
      logic [3:0]      col;
      logic [2:0]      res;
      logic [ID_W-1:0] ship;
      int              shot_idx;   // -1: no shot pulse
      int              res_cyc;
      logic [99:0]     sunk;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] c, input logic [2:0] res,
                               input logic [ID_W-1:0] s, input int si, input int rc, input logic [99:0] m);
      vec_t v;
      v.row = r; v.col = c; v.res = res; v.ship = s; v.shot_idx = si; v.res_cyc = rc; v.sunk = m;
      return v;
   endfunction

   // Issues one request and records, per cycle after the handshake, what the DUT showed.
   task automatic fire(input logic [3:0] r, input logic [3:0] c,
                       output int res_cyc, output logic [2:0] res, output logic [ID_W-1:0] rs,
                       output int shot_cyc, output logic [99:0] shot_v,
                       output int sunk_cyc, output logic [99:0] sunk_v);
      int w;
      res_cyc = -1; shot_cyc = -1; sunk_cyc = -1;
      res = '0; rs = '0; shot_v = '0; sunk_v = '0;
      @(negedge clk);
      fire_valid = 1'b1; fire_row = r; fire_col = c;
      w = 0;
      while (!fire_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!fire_ready) begin
         fire_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 fire_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (shot != '0 && shot_cyc < 0) begin shot_cyc = k; shot_v = shot; end
         if (ship_sunk != '0 && sunk_cyc < 0) begin sunk_cyc = k; sunk_v = ship_sunk; end
         if (result_valid) begin
            res_cyc = k; res = result; rs = result_ship;
            break;
         end
      end
   endtask

   vec_t            vecs [11];
   logic [99:0]     m1, m2, one;
   int              rc, sc, kc;
   logic [2:0]      rr;
   logic [ID_W-1:0] rs;
   logic [99:0]     sv, kv;
   logic            seen;

   initial begin
      one = 100'd1;
      m1 = '0;
      foreach (m1[i]) if (i inside {11,12,13,14,21,22,23,24,31,32,33,34}) m1[i] = 1'b1;
      m2 = '0;
      foreach (m2[i]) if (i inside {8,9,18,19,28,29}) m2[i] = 1'b1;

      vecs[0]  = mk(4'd5,  4'd5,  MISS,    0, 55, 3, '0);
      vecs[1]  = mk(4'd2,  4'd2,  HIT,     1, 22, 3, '0);
      vecs[2]  = mk(4'd2,  4'd3,  SUNK,    1, 23, 4, m1);
      vecs[3]  = mk(4'd0,  4'd0,  MISS,    0,  0, 3, '0);
      vecs[4]  = mk(4'd0,  4'd0,  REPEAT,  0, -1, 2, '0);
      vecs[5]  = mk(4'd10, 4'd3,  INVALID, 0, -1, 2, '0);
      vecs[6]  = mk(4'd4,  4'd15, INVALID, 0, -1, 2, '0);
      vecs[7]  = mk(4'd2,  4'd2,  REPEAT,  0, -1, 2, '0);
      vecs[8]  = mk(4'd0,  4'd1,  MISS,    0,  1, 3, '0);
      vecs[9]  = mk(4'd0,  4'd9,  HIT,     2,  9, 3, '0);
      vecs[10] = mk(4'd1,  4'd9,  SUNK,    2, 19, 4, m2);

      reset_n = 1'b0; map_load = 1'b0; fire_valid = 1'b0; fire_row = '0; fire_col = '0;
      ship_id_flat = '0; ship_len_flat = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_shot", shot, '0);
      chk("rst_sunk", ship_sunk, '0);
      chk("rst_rvalid", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_rship", result_ship, 0);
      chk("rst_gameover", game_over, 0);
      chk("rst_ready", fire_ready, 1);
      chk("rst_isship", is_ship, '0);

      // Empty map: a shot is a plain MISS and does not end the game.
      fire(4'd5, 4'd5, rc, rr, rs, sc, sv, kc, kv);
      chk("empty_result", rr, MISS);
      chk("empty_cyc", rc, 3);
      @(negedge clk);
      chk("empty_gameover", game_over, 0);

      ship_id_flat[22*ID_W +: ID_W] = 3'd1;
      ship_id_flat[23*ID_W +: ID_W] = 3'd1;
      ship_id_flat[9*ID_W  +: ID_W] = 3'd2;
      ship_id_flat[19*ID_W +: ID_W] = 3'd2;
      ship_len_flat[0 +: LEN_W]     = 3'd2;
      ship_len_flat[LEN_W +: LEN_W] = 3'd2;

      // map_load wins over a simultaneous fire request.
      @(negedge clk);
      map_load = 1'b1; fire_valid = 1'b1; fire_row = 4'd5; fire_col = 4'd5;
      @(negedge clk);
      map_load = 1'b0; fire_valid = 1'b0;
      chk("load_ready", fire_ready, 1);
      chk("load_isship", is_ship, (one << 22) | (one << 23) | (one << 9) | (one << 19));
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
      end
      chk("load_noresp", seen, 0);

      for (int i = 0; i < 11; i++) begin
         fire(vecs[i].row, vecs[i].col, rc, rr, rs, sc, sv, kc, kv);
         chk($sformatf("v%0d_result", i), rr, vecs[i].res);
         chk($sformatf("v%0d_ship", i), rs, vecs[i].ship);
         chk($sformatf("v%0d_rcyc", i), rc, vecs[i].res_cyc);
         chk($sformatf("v%0d_shotcyc", i), sc, (vecs[i].shot_idx < 0) ? -1 : 2);
         chk($sformatf("v%0d_shot", i), sv, (vecs[i].shot_idx < 0) ? '0 : (one << vecs[i].shot_idx));
         chk($sformatf("v%0d_sunkcyc", i), kc, (vecs[i].sunk == '0) ? -1 : 3);
         chk($sformatf("v%0d_sunk", i), kv, vecs[i].sunk);
         @(negedge clk);
         chk($sformatf("v%0d_gameover", i), game_over, (i == 10) ? 1 : 0);
         chk($sformatf("v%0d_ready", i), fire_ready, (i == 10) ? 0 : 1);
      end

      // After game over, requests are ignored.
      fire_valid = 1'b1; fire_row = 4'd3; fire_col = 4'd3;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (result_valid || shot != '0) seen = 1'b1;
      end
      fire_valid = 1'b0;
      chk("over_ignored", seen, 0);

      map_load = 1'b1;
      @(negedge clk);
      map_load = 1'b0;
      chk("reload_gameover", game_over, 0);
      chk("reload_ready", fire_ready, 1);
      fire(4'd2, 4'd2, rc, rr, rs, sc, sv, kc, kv);
      chk("reload_result", rr, HIT);
      chk("reload_ship", rs, 1);

      // Reset while the shot pulse is on the wire.
      @(negedge clk);
      fire_valid = 1'b1; fire_row = 4'd2; fire_col = 4'd3;
      @(posedge clk);
      #1 fire_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_shot_before", shot, one << 23);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_shot", shot, '0);
      chk("midrst_sunk", ship_sunk, '0);
      chk("midrst_rvalid", result_valid, 0);
      chk("midrst_result", result, 0);
      chk("midrst_rship", result_ship, 0);
      chk("midrst_gameover", game_over, 0);
      chk("midrst_isship", is_ship, '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", fire_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
